servo_sweep: RTL and testbench

- Position-command generator that drives the `val` input of the `servo` pulse module; replaces the free-running sawtooth signal in the servo demo top.
- Steps an 8-bit position between programmable `min_val` and `max_val` at a prescaled rate.
- Produces either a sawtooth (ramp up, wrap) or a triangle (ramp up, ramp down).
- The output is registered, so it can feed `servo.val` directly.

---
 rtl/servo_sweep.sv | 168 ++++++++++++++++
 tb/tb_servo_sweep.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/servo_sweep.sv
// servo_sweep: sawtooth/triangle position command for servo.val.
// Define SWEEP_DWELL_EN to hold DWELL ticks at each sweep endpoint.
module servo_sweep #(
   parameter int WIDTH    = 8,
   parameter int STEP_DIV = 200000,
   parameter int DWELL    = 25
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             mode,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] val,
   output logic             step,
   output logic             at_end
);

   localparam int PW = $clog2(STEP_DIV);
   localparam logic [PW-1:0] PS_TC = PW'(STEP_DIV - 1);

`ifdef SWEEP_DWELL_EN
   typedef enum logic [1:0] {
      UP,
      DOWN,
      DWELL_HI,
      DWELL_LO
   } state_t;

   localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [DW-1:0] DW_TC = DW'((DWELL > 0) ? DWELL - 1 : 0);
   // DWELL=0 never enters the dwell states
   localparam state_t HI_NEXT = (DWELL > 0) ? DWELL_HI : DOWN;
   localparam state_t LO_NEXT = (DWELL > 0) ? DWELL_LO : UP;

   logic [DW-1:0] dcnt;
`else
   typedef enum logic {
      UP,
      DOWN
   } state_t;

   localparam state_t HI_NEXT = DOWN;
   localparam state_t LO_NEXT = UP;

   logic unused_dwell;
   assign unused_dwell = ^DWELL;
`endif

   state_t           state;
   logic [PW-1:0]    pcnt;
   logic             tick;
   logic             degen;
   logic             below;
   logic             above;
   logic             at_lo;
   logic             at_hi;
   logic             mid;
   logic             rise;
   logic [WIDTH-1:0] up_v;
   logic [WIDTH-1:0] dn_v;

   assign tick  = en && (pcnt == PS_TC);
   assign degen = (min_val >= max_val);
   assign below = (val < min_val);
   assign above = (val > max_val);
   assign at_lo = (val == min_val);
   assign at_hi = (val == max_val);
   assign mid   = (val > min_val) && (val < max_val);
   assign up_v  = val + WIDTH'(1);
   assign dn_v  = val - WIDTH'(1);
   // DOWN with sawtooth selected continues upward from the current val
   assign rise  = (state == UP) || !mode;

   assign at_end = degen || at_lo || at_hi;

   // Step prescaler: free-runs while enabled, frozen otherwise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt <= '0;
      end else if (en) begin
         pcnt <= tick ? '0 : pcnt + PW'(1);
      end
   end

   // Sweep FSM: position, direction and step pulse update once per tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val   <= '0;
         step  <= 1'b0;
         state <= UP;
`ifdef SWEEP_DWELL_EN
         dcnt  <= '0;
`endif
      end else begin
         step <= tick;
         if (tick) begin
`ifdef SWEEP_DWELL_EN
            dcnt <= '0;
`endif
            if (degen) begin
               val   <= min_val;
               state <= UP;
            end else begin
               unique case (state)
                  UP, DOWN: begin
                     if (rise) begin
                        unique case (1'b1)
                           below: begin
                              val   <= min_val;
                              state <= UP;
                           end
                           at_lo, mid: begin
                              val   <= up_v;
                              state <= (mode && up_v == max_val) ?
                                       HI_NEXT : UP;
                           end
                           at_hi: begin
                              if (mode) begin
                                 state <= HI_NEXT;
                              end else begin
                                 val   <= min_val;
                                 state <= LO_NEXT;
                              end
                           end
                           above: begin
                              val   <= max_val;
                              state <= mode ? HI_NEXT : UP;
                           end
                        endcase
                     end else begin
                        unique case (1'b1)
                           below, at_lo: begin
                              val   <= min_val;
                              state <= LO_NEXT;
                           end
                           mid, at_hi: begin
                              val   <= dn_v;
                              state <= (dn_v == min_val) ?
                                       LO_NEXT : DOWN;
                           end
                           above: begin
                              val <= max_val;
                           end
                        endcase
                     end
                  end
`ifdef SWEEP_DWELL_EN
                  DWELL_HI, DWELL_LO: begin
                     if (below) begin
                        val <= min_val;
                     end else if (above) begin
                        val <= max_val;
                     end
                     if (dcnt == DW_TC) begin
                        state <= (state == DWELL_HI) ? DOWN : UP;
                     end else begin
                        dcnt <= dcnt + DW'(1);
                     end
                  end
`endif
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_servo_sweep.sv
// tb_servo_sweep: scoreboard bench for servo_sweep.
// STEP_DIV=4, DWELL=2; expectations follow SWEEP_DWELL_EN if defined.
module tb_servo_sweep;

   localparam int W  = 8;
   localparam int SD = 4;
   localparam int DW = 2;
`ifdef SWEEP_DWELL_EN
   localparam int HOLD = DW;
`else
   localparam int HOLD = 0;
`endif

   typedef struct {
      logic [W-1:0] v;
      logic         ae;
      int           gap;
   } exp_t;

   exp_t q[$];
   exp_t e_m;

   logic         clk     = 1'b0;
   logic         rst_n   = 1'b1;
   logic         en      = 1'b1;
   logic         mode    = 1'b0;
   logic [W-1:0] min_val = 8'd0;
   logic [W-1:0] max_val = 8'd3;
   logic [W-1:0] val;
   logic         step;
   logic         at_end;

   int tests = 0;
   int fails = 0;
   int since = 0;

   servo_sweep #(
      .WIDTH    (W),
      .STEP_DIV (SD),
      .DWELL    (DW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .min_val (min_val),
      .max_val (max_val),
      .val     (val),
      .step    (step),
      .at_end  (at_end)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] v, input int gap);
      exp_t e;
      e.v   = v;
      e.ae  = (v == min_val) || (v == max_val) || (min_val >= max_val);
      e.gap = gap;
      q.push_back(e);
   endtask

   task automatic push_n(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) push(v, SD);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (q.size() != 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d steps missing after %0d cycles",
                  q.size(), budget);
         q.delete();
      end
   endtask

   task automatic wait_step_hi(input int budget);
      int n = 1;
      @(negedge clk);
      while (!step && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (!step) begin
         tests++;
         fails++;
         $display("FAIL step_wait: no step within %0d cycles", budget);
      end
      #1;
   endtask

   task automatic do_reset;
      @(negedge clk);
      #1 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   // Monitor: every step pulse pops one expected entry
   initial forever begin
      @(negedge clk);
      if (!rst_n) begin
         since = 0;
      end else begin
         since++;
         if (step) begin
            if (q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_step: val %0d, queue empty", val);
            end else begin
               e_m = q.pop_front();
               chk("val", val, e_m.v);
               chk("at_end", at_end, e_m.ae);
               chk("step_gap", since, e_m.gap);
            end
            since = 0;
         end
      end
   end

   initial begin
      #1 rst_n = 1'b0;
      #10;
      chk("rst_val", val, 0);
      chk("rst_step", step, 0);
      chk("rst_at_end", at_end, 1);

      // sawtooth 0..3
      push(1, SD); push(2, SD); push(3, SD); push(0, SD);
      push_n(0, HOLD);
      push(1, SD); push(2, SD);
      do_reset;
      wait_drain(2000);

      // triangle 2..5 from val=0
      mode = 1'b1; min_val = 8'd2; max_val = 8'd5;
      push(2, SD); push(3, SD); push(4, SD); push(5, SD);
      push_n(5, HOLD);
      push(4, SD); push(3, SD); push(2, SD);
      push_n(2, HOLD);
      push(3, SD);
      do_reset;
      wait_drain(2000);

      // max drops below val mid-ramp
      mode = 1'b1; min_val = 8'd0; max_val = 8'd200;
      for (int v = 1; v <= 150; v++) push(W'(v), SD);
      do_reset;
      wait_drain(3000);
      max_val = 8'd100;
      push(100, SD);
      push_n(100, HOLD);
      push(99, SD); push(98, SD);
      wait_drain(2000);

      // degenerate limits
      min_val = 8'd7; max_val = 8'd7;
      push_n(7, 3);
      wait_drain(2000);
      chk("eq_at_end", at_end, 1);
      min_val = 8'd9; max_val = 8'd4;
      push_n(9, 3);
      wait_drain(2000);
      chk("inv_val", val, 9);
      chk("inv_at_end", at_end, 1);

      // enable freeze
      mode = 1'b0; min_val = 8'd10; max_val = 8'd20;
      push(10, SD); push(11, SD);
      wait_drain(2000);
      en = 1'b0;
      push(12, SD + 10);
      push(13, SD);
      repeat (5) @(posedge clk);
      #1;
      chk("frz_val", val, 11);
      chk("frz_step", step, 0);
      repeat (5) @(posedge clk);
      #1 en = 1'b1;
      wait_drain(2000);

      // async reset while step is high
      push(14, SD);
      wait_step_hi(20);
      rst_n = 1'b0;
      #1;
      chk("arst_val", val, 0);
      chk("arst_step", step, 0);
      chk("arst_at_end", at_end, 0);
      chk("queue_empty", q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
